serial_cmd_frame_decoder: RTL

Parametrised successor of the serial command decoder: pops bytes from the receive FIFO, validates the frame SOF SOF SPACE LEN PAYLOAD[LEN] EOF EOF, and exposes payload, length, status and error code to the command processor. It adds the following over the fixed-size decoder:
- configurable payload depth and frame bytes;
- explicit error codes;
- a FIFO-empty timeout;
- automatic FIFO drain after a malformed frame;
- an optional checksum byte.

It sits between the UART RX FIFO and the command executor.

---
 rtl/serial_cmd_frame_decoder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_cmd_frame_decoder.sv
// Pops SOF SOF SPACE LEN PAYLOAD[LEN] [CSUM] EOF EOF frames from the RX FIFO and reports result/error to the executor.
// SERIAL_CMD_CHECKSUM_EN inserts an XOR checksum byte (LEN ^ payload bytes) between payload and EOF1.
module serial_cmd_frame_decoder #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 8,
  parameter logic [7:0]  SOF_BYTE          = 8'hFF,
  parameter logic [7:0]  SPACE_BYTE        = 8'h00,
  parameter logic [7:0]  EOF_BYTE          = 8'hEE,
  parameter int unsigned EMPTY_TIMEOUT     = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_ready,
  input  logic [7:0]                     data,
  input  logic                           fifo_empty,
  input  logic                           cmd_processed_received,
  output logic                           cmd_read_clk,
  output logic                           cmd_processed,
  output logic                           cmd_decode_success,
  output logic [2:0]                     cmd_error_code,
  output logic [7:0]                     cmd_bytes_processed,
  output logic [7:0]                     cmd_payload_len,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] cmd_payload
);

  localparam int unsigned TW       = $clog2(EMPTY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(EMPTY_TIMEOUT - 1);
  localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD_BYTES);

  localparam logic [2:0] ERR_SOF   = 3'd1;
  localparam logic [2:0] ERR_SPACE = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_EOF   = 3'd4;
  localparam logic [2:0] ERR_TMO   = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF1,
    ST_SOF2,
    ST_SPACE,
    ST_LEN,
    ST_PAYLOAD,
`ifdef SERIAL_CMD_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_EOF1,
    ST_EOF2,
    ST_DRAIN,
    ST_DONE
  } state_t;

`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam state_t ST_POST_PAY = ST_CSUM;
  localparam logic [2:0] ERR_CSUM = 3'd5;
`else
  localparam state_t ST_POST_PAY = ST_EOF1;
`endif

  state_t                         state_q, state_d;
  logic                           wait_q, wait_d;
  logic                           read_q, read_d;
  logic                           succ_q, succ_d;
  logic [2:0]                     err_q, err_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic [7:0]                     len_q, len_d;
  logic [7:0]                     idx_q, idx_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic [8*MAX_PAYLOAD_BYTES-1:0] payload_q, payload_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0]                     csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    read_d    = 1'b0;
    succ_d    = succ_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    payload_d = payload_q;
`ifdef SERIAL_CMD_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_ready) begin
          state_d   = ST_SOF1;
          wait_d    = 1'b0;
          succ_d    = 1'b0;
          err_d     = 3'd0;
          cnt_d     = 8'd0;
          len_d     = 8'd0;
          idx_d     = 8'd0;
          tmo_d     = '0;
          payload_d = '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
          csum_d    = 8'd0;
`endif
        end
      end
      ST_DONE: begin
        if (cmd_processed_received) state_d = ST_IDLE;
      end
      default: begin
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (fifo_empty) begin
          // Drain ends on the first empty FETCH; other states count towards the timeout.
          if (state_q == ST_DRAIN) begin
            state_d = ST_DONE;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = ERR_TMO;
            state_d = ST_DONE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          read_d = 1'b1;
          wait_d = 1'b1;
          tmo_d  = '0;
          cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          case (state_q)
            ST_SOF1: begin
              if (data == SOF_BYTE) state_d = ST_SOF2;
              else begin err_d = ERR_SOF; state_d = ST_DRAIN; end
            end
            ST_SOF2: begin
              if (data == SOF_BYTE) state_d = ST_SPACE;
              else begin err_d = ERR_SOF; state_d = ST_DRAIN; end
            end
            ST_SPACE: begin
              if (data == SPACE_BYTE) state_d = ST_LEN;
              else begin err_d = ERR_SPACE; state_d = ST_DRAIN; end
            end
            ST_LEN: begin
              len_d = data;
`ifdef SERIAL_CMD_CHECKSUM_EN
              csum_d = data;
`endif
              if (data > MAX_LEN) begin
                err_d   = ERR_LEN;
                state_d = ST_DRAIN;
              end else if (data == 8'd0) begin
                state_d = ST_POST_PAY;
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              for (int i = 0; i < int'(MAX_PAYLOAD_BYTES); i++) begin
                if (idx_q == 8'(i)) payload_d[8*i +: 8] = data;
              end
`ifdef SERIAL_CMD_CHECKSUM_EN
              csum_d = csum_q ^ data;
`endif
              idx_d = idx_q + 8'd1;
              if (idx_q + 8'd1 == len_q) state_d = ST_POST_PAY;
            end
`ifdef SERIAL_CMD_CHECKSUM_EN
            ST_CSUM: begin
              if (data == csum_q) state_d = ST_EOF1;
              else begin err_d = ERR_CSUM; state_d = ST_DRAIN; end
            end
`endif
            ST_EOF1: begin
              if (data == EOF_BYTE) state_d = ST_EOF2;
              else begin err_d = ERR_EOF; state_d = ST_DRAIN; end
            end
            ST_EOF2: begin
              // A good frame reports immediately; the pop pulse overlaps the first DONE cycle.
              if (data == EOF_BYTE) begin
                succ_d  = 1'b1;
                wait_d  = 1'b0;
                state_d = ST_DONE;
              end else begin
                err_d   = ERR_EOF;
                state_d = ST_DRAIN;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= 1'b0;
      read_q    <= 1'b0;
      succ_q    <= 1'b0;
      err_q     <= 3'd0;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      tmo_q     <= '0;
      payload_q <= '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      read_q    <= read_d;
      succ_q    <= succ_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign cmd_read_clk        = read_q;
  assign cmd_processed       = (state_q == ST_DONE);
  assign cmd_decode_success  = succ_q;
  assign cmd_error_code      = err_q;
  assign cmd_bytes_processed = cnt_q;
  assign cmd_payload_len     = len_q;
  assign cmd_payload         = payload_q;

endmodule
